servant_irq_sched: RTL and testbench
====================================

// Module: servant_irq_sched
// PURPOSE
//  Simulation-side external-interrupt scheduler for the servant SoC bench. Drives the
//  core's ext_irq pin on a programmable cycle schedule and holds it until the handler
//  retires (mret), then re-arms. Uses the retire/PC-valid trace to measure each
//  handler's latency and instruction count, and flags hung or spurious handlers.
//  Sits beside the DUT in the bench top; its outputs are observed by the test.
// PARAMETERS
//  INTERRUPT_TIME  3000  cycles from enable to the first ext_irq assertion (>=1)
//  PERIOD          0     cycles from handler mret to the next assertion; 0 = one-shot
//  MAX_IRQS        4     interrupts to issue before stopping (1..255)
//  TIMEOUT         2000  max cycles ext_irq may stay high without mret (>=2)
//  CW              16    width of the latency and instruction counters
// PORTS
//  wb_clk        in   1   clock
//  wb_rst_n      in   1   asynchronous active-low reset
//  i_en          in   1   scheduler enable; level-sensitive
//  i_pc_vld      in   1   instruction-fetch ack pulse from the core
//  i_mret        in   1   mret retire pulse from the core
//  o_ext_irq     out  1   external interrupt to the core
//  o_busy        out  1   high in WAIT or PEND
//  o_done        out  1   high in DONE
//  o_irq_cnt     out  8   handlers completed with mret; saturates at 255
//  o_last_lat    out  CW  ext_irq-rise-to-mret cycles of the last completed handler
//  o_last_insns  out  CW  i_pc_vld pulses counted during that handler
//  o_timeout     out  1   sticky: a handler exceeded TIMEOUT
//  o_spurious    out  1   sticky: i_mret seen while ext_irq was low
// BEHAVIOUR
//  Reset (async, wb_rst_n=0): state IDLE; every output and counter is 0.
//  States IDLE, WAIT, PEND, DONE. All outputs are registered.
//  IDLE: o_ext_irq=0. On i_en=1, go to WAIT and load timer=INTERRUPT_TIME-1.
//  WAIT: the timer decrements every cycle. At timer==0, go to PEND, set o_ext_irq=1,
//   clear lat/insn counters. o_ext_irq therefore rises exactly INTERRUPT_TIME edges
//   after the edge that sampled i_en=1 in IDLE.
//  PEND: lat increments every cycle; insn increments on each i_pc_vld. Both
//   saturate at 2^CW-1.
//   On i_mret=1:
//    - o_ext_irq=0 on the next edge.
//    - o_irq_cnt++ (saturating).
//    - o_last_lat=lat+1 and o_last_insns=insn (+1 if i_pc_vld is also high).
//    - If PERIOD==0 or the completed count reaches MAX_IRQS, go to DONE.
//    - Otherwise go to WAIT and load timer=PERIOD-1.
//   If lat reaches TIMEOUT-1 without mret: set o_timeout, o_ext_irq=0, go to DONE;
//   o_irq_cnt and o_last_* are not updated.
//   mret on the same edge as the timeout: mret wins and the timeout is not flagged.
//  DONE: o_ext_irq=0, o_done=1. Stay here until i_en=0, then go to IDLE.
//   o_irq_cnt, o_last_*, o_timeout and o_spurious are held.
//  i_en=0 in WAIT or PEND: abort to IDLE on the next edge, o_ext_irq=0, no count update.
//  Re-enabling from IDLE clears o_irq_cnt, o_timeout and o_spurious (same edge as
//   the IDLE->WAIT transition).
//  i_mret while o_ext_irq==0 in any state: set o_spurious. No other effect.
//  i_mret on the edge ext_irq rises (WAIT->PEND): counts as spurious, not completion.
//  i_pc_vld outside PEND is ignored.
// TESTING
//  1 INTERRUPT_TIME=10, PERIOD=0; i_en=1 at cycle 0; mret 25 cycles after irq rise
//    -> irq rises at cycle 10 and falls at cycle 36; o_last_lat=26; o_irq_cnt=1;
//    o_done=1.
//  2 PERIOD=50, MAX_IRQS=3; each handler ends with mret after 5 cycles
//    -> three irq pulses, each starting 50 cycles after the previous mret;
//    o_irq_cnt=3; DONE.
//  3 TIMEOUT=100; no mret -> irq high exactly 100 cycles; o_timeout=1; o_irq_cnt=0;
//    DONE.
//  4 i_pc_vld every 4th cycle during a 40-cycle handler -> o_last_insns=10;
//    mret in WAIT -> o_spurious=1 and o_irq_cnt unchanged.
//  5 wb_rst_n low mid-PEND -> o_ext_irq low asynchronously, before the next edge;
//    all outputs 0. i_en drop mid-WAIT -> IDLE, no irq issued.
//  6 mret coincident with the timeout edge -> o_timeout=0, o_irq_cnt+1.

Source files
------------

// File: rtl/servant_irq_sched.sv
// External-interrupt scheduler for the servant SoC bench: raises ext_irq on a cycle
// schedule, holds it until mret, and records per-handler latency and instruction count.
module servant_irq_sched #(
  parameter int unsigned INTERRUPT_TIME = 3000,
  parameter int unsigned PERIOD         = 0,
  parameter int unsigned MAX_IRQS       = 4,
  parameter int unsigned TIMEOUT        = 2000,
  parameter int unsigned CW             = 16
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          i_en,
  input  logic          i_pc_vld,
  input  logic          i_mret,
  output logic          o_ext_irq,
  output logic          o_busy,
  output logic          o_done,
  output logic [7:0]    o_irq_cnt,
  output logic [CW-1:0] o_last_lat,
  output logic [CW-1:0] o_last_insns,
  output logic          o_timeout,
  output logic          o_spurious
);

  typedef enum logic [1:0] {IDLE, WAIT, PEND, DONE} state_e;

  localparam logic [31:0]   IT_LOAD  = INTERRUPT_TIME - 1;
  localparam logic [31:0]   PER_LOAD = PERIOD - 1;
  localparam logic [31:0]   TO_LAST  = TIMEOUT - 1;
  localparam logic [7:0]    MAX_CNT  = 8'(MAX_IRQS);
  localparam logic [CW-1:0] CMAX     = '1;

  state_e        state_q, state_d;
  logic [31:0]   timer_q, timer_d;
  logic          irq_q, irq_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [CW-1:0] lat_q, lat_d;
  logic [CW-1:0] insn_q, insn_d;
  logic [CW-1:0] last_lat_q, last_lat_d;
  logic [CW-1:0] last_insns_q, last_insns_d;
  logic          timeout_q, timeout_d;
  logic          spur_q, spur_d;

  logic [CW-1:0] lat_inc, insn_inc;
  logic [7:0]    cnt_inc;

  always_comb begin
    lat_inc  = (lat_q  == CMAX)  ? lat_q  : lat_q  + 1'b1;
    insn_inc = (insn_q == CMAX)  ? insn_q : insn_q + 1'b1;
    cnt_inc  = (cnt_q  == 8'hFF) ? cnt_q  : cnt_q  + 8'd1;

    state_d      = state_q;
    timer_d      = timer_q;
    irq_d        = irq_q;
    cnt_d        = cnt_q;
    lat_d        = lat_q;
    insn_d       = insn_q;
    last_lat_d   = last_lat_q;
    last_insns_d = last_insns_q;
    timeout_d    = timeout_q;
    spur_d       = spur_q;

    case (state_q)
      IDLE: begin
        if (i_en) begin
          state_d   = WAIT;
          timer_d   = IT_LOAD;
          cnt_d     = '0;
          timeout_d = 1'b0;
          spur_d    = 1'b0;
        end
      end
      WAIT: begin
        if (!i_en) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          state_d = PEND;
          irq_d   = 1'b1;
          lat_d   = '0;
          insn_d  = '0;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      PEND: begin
        // Priority: abort, then mret (beats a coincident timeout), then timeout.
        if (!i_en) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end else if (i_mret) begin
          irq_d        = 1'b0;
          cnt_d        = cnt_inc;
          last_lat_d   = lat_inc;
          last_insns_d = i_pc_vld ? insn_inc : insn_q;
          if (PERIOD == 0 || cnt_inc >= MAX_CNT) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            timer_d = PER_LOAD;
          end
        end else if (32'(lat_q) == TO_LAST) begin
          timeout_d = 1'b1;
          irq_d     = 1'b0;
          state_d   = DONE;
        end else begin
          lat_d = lat_inc;
          if (i_pc_vld) insn_d = insn_inc;
        end
      end
      DONE: begin
        if (!i_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (i_mret && !irq_q) spur_d = 1'b1;

    busy_d = (state_d == WAIT) || (state_d == PEND);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      irq_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      lat_q        <= '0;
      insn_q       <= '0;
      last_lat_q   <= '0;
      last_insns_q <= '0;
      timeout_q    <= 1'b0;
      spur_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      irq_q        <= irq_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      lat_q        <= lat_d;
      insn_q       <= insn_d;
      last_lat_q   <= last_lat_d;
      last_insns_q <= last_insns_d;
      timeout_q    <= timeout_d;
      spur_q       <= spur_d;
    end
  end

  assign o_ext_irq    = irq_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_irq_cnt    = cnt_q;
  assign o_last_lat   = last_lat_q;
  assign o_last_insns = last_insns_q;
  assign o_timeout    = timeout_q;
  assign o_spurious   = spur_q;

endmodule

// File: tb/tb_servant_irq_sched.sv
// Bench for servant_irq_sched: a periodic instance driven through a rise/completion
// scoreboard, plus a one-shot instance checked directly.
module tb_servant_irq_sched;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          en = 1'b0, pcv = 1'b0, mret = 1'b0;
  logic          irq, busy, done, tmo, spur;
  logic [7:0]    cnt;
  logic [CW-1:0] lat, insns;

  logic          en1 = 1'b0, pcv1 = 1'b0, mret1 = 1'b0;
  logic          irq1, busy1, done1, tmo1, spur1;
  logic [7:0]    cnt1;
  logic [CW-1:0] lat1, insns1;

  servant_irq_sched #(.INTERRUPT_TIME(10), .PERIOD(50), .MAX_IRQS(3), .TIMEOUT(100), .CW(CW)) u_dut (
    .wb_clk(clk), .wb_rst_n(rst_n), .i_en(en), .i_pc_vld(pcv), .i_mret(mret),
    .o_ext_irq(irq), .o_busy(busy), .o_done(done), .o_irq_cnt(cnt),
    .o_last_lat(lat), .o_last_insns(insns), .o_timeout(tmo), .o_spurious(spur)
  );

  servant_irq_sched #(.INTERRUPT_TIME(10), .PERIOD(0), .MAX_IRQS(4), .TIMEOUT(2000), .CW(CW)) u_one (
    .wb_clk(clk), .wb_rst_n(rst_n), .i_en(en1), .i_pc_vld(pcv1), .i_mret(mret1),
    .o_ext_irq(irq1), .o_busy(busy1), .o_done(done1), .o_irq_cnt(cnt1),
    .o_last_lat(lat1), .o_last_insns(insns1), .o_timeout(tmo1), .o_spurious(spur1)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int lat;
    int insns;
    int cnt;
  } comp_t;

  int unsigned rise_q[$];
  comp_t       comp_q[$];
  int          exp_cnt = 0;

  // Scoreboard monitor: pops an expectation whenever the DUT produces a rise or a completion.
  logic       irq_prev = 1'b0;
  logic [7:0] cnt_prev = '0;
  always @(negedge clk) begin
    if (irq === 1'b1 && irq_prev !== 1'b1) begin
      if (rise_q.size() == 0) chk("unexpected_rise", 64'(cyc), 64'd0);
      else                    chk("rise_cycle", 64'(cyc), 64'(rise_q.pop_front()));
    end
    if (cnt > cnt_prev) begin
      if (comp_q.size() == 0) begin
        chk("unexpected_completion", 64'(cnt), 64'(cnt_prev));
      end else begin
        comp_t c;
        c = comp_q.pop_front();
        chk("last_lat", 64'(lat), 64'(c.lat));
        chk("last_insns", 64'(insns), 64'(c.insns));
        chk("irq_cnt", 64'(cnt), 64'(c.cnt));
        chk("irq_low_after_mret", 64'(irq), 64'd0);
      end
    end
    irq_prev = irq;
    cnt_prev = cnt;
  end

  task automatic enable_main();
    en = 1'b1;
    exp_cnt = 0;
    rise_q.push_back(cyc + 11);
    @(negedge clk);
  endtask

  task automatic wait_irq(output int unsigned r);
    int w = 0;
    while (irq !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("irq_wait", 64'(irq), 64'd1);
    r = cyc;
  endtask

  // Handler with mret sampled L edges after the rise; pc_vld on every pe-th edge.
  task automatic handler(input int L, input int pe, input bit more);
    int unsigned r;
    int n = 0;
    wait_irq(r);
    for (int k = 1; k <= L; k++) begin
      pcv  = (pe != 0) && (k % pe == 0);
      mret = (k == L);
      if (pcv) n++;
      if (k == L) begin
        exp_cnt++;
        comp_q.push_back('{lat: L, insns: n, cnt: exp_cnt});
        if (more) rise_q.push_back(cyc + 1 + 50);
      end
      @(negedge clk);
    end
    pcv  = 1'b0;
    mret = 1'b0;
  endtask

  initial begin
    #(10 * 40000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned r, n;

    #2;
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_lat", 64'(lat), 64'd0);
    chk("rst_flags", 64'({tmo, spur}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // One-shot: rise 10 edges after enable, mret at lat 25 -> falls at edge 26.
    n = cyc;
    en1 = 1'b1;
    while (cyc < n + 10) @(negedge clk);
    chk("one_irq_before", 64'(irq1), 64'd0);
    @(negedge clk);
    chk("one_irq_rise", 64'(irq1), 64'd1);
    r = cyc;
    repeat (25) @(negedge clk);
    chk("one_irq_held", 64'(irq1), 64'd1);
    mret1 = 1'b1;
    @(negedge clk);
    mret1 = 1'b0;
    chk("one_irq_fall", 64'(cyc - r), 64'd26);
    chk("one_irq_low", 64'(irq1), 64'd0);
    chk("one_last_lat", 64'(lat1), 64'd26);
    chk("one_irq_cnt", 64'(cnt1), 64'd1);
    chk("one_done", 64'(done1), 64'd1);
    chk("one_spurious", 64'(spur1), 64'd0);

    // Periodic: three handlers of 5 cycles, PERIOD=50.
    enable_main();
    handler(5, 0, 1);
    handler(5, 0, 1);
    handler(5, 0, 0);
    chk("per_done", 64'(done), 64'd1);
    chk("per_busy", 64'(busy), 64'd0);
    chk("per_cnt", 64'(cnt), 64'd3);
    en = 1'b0;
    @(negedge clk);
    chk("per_idle_done", 64'(done), 64'd0);

    // Timeout: no mret, irq high exactly 100 cycles.
    enable_main();
    wait_irq(r);
    repeat (99) @(negedge clk);
    chk("to_irq_held", 64'(irq), 64'd1);
    chk("to_not_yet", 64'(tmo), 64'd0);
    @(negedge clk);
    chk("to_irq_low", 64'(irq), 64'd0);
    chk("to_flag", 64'(tmo), 64'd1);
    chk("to_cnt", 64'(cnt), 64'd0);
    chk("to_done", 64'(done), 64'd1);
    en = 1'b0;
    @(negedge clk);

    // mret on the timeout edge: completion wins; then drop enable mid-WAIT.
    enable_main();
    chk("reen_clears_to", 64'(tmo), 64'd0);
    handler(100, 0, 0);
    chk("race_to", 64'(tmo), 64'd0);
    chk("race_cnt", 64'(cnt), 64'd1);
    chk("race_busy", 64'(busy), 64'd1);
    en = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (60) @(negedge clk);
    chk("abort_irq", 64'(irq), 64'd0);
    chk("abort_cnt", 64'(cnt), 64'd1);

    // Spurious mret in WAIT, then a 40-cycle handler with pc_vld every 4th cycle.
    enable_main();
    repeat (2) @(negedge clk);
    mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
    chk("spur_flag", 64'(spur), 64'd1);
    chk("spur_cnt", 64'(cnt), 64'd0);
    chk("spur_busy", 64'(busy), 64'd1);
    handler(40, 4, 0);
    chk("spur_held", 64'(spur), 64'd1);
    en = 1'b0;
    @(negedge clk);

    // Async reset mid-PEND.
    enable_main();
    wait_irq(r);
    repeat (3) @(negedge clk);
    chk("pre_rst_irq", 64'(irq), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_irq", 64'(irq), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_cnt", 64'(cnt), 64'd0);
    chk("arst_last", 64'({lat, insns}), 64'd0);
    chk("arst_flags", 64'({tmo, spur, done}), 64'd0);
    chk("arst_one", 64'({irq1, done1, cnt1}), 64'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("queues_drained", 64'(rise_q.size() + comp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
